// File: rtl/square_wave_meter_pkg.sv
// Shared FSM encoding and default parameter values for the square-wave meter.
package square_wave_meter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_GATE  = 3'd2,
    ST_CLOSE = 3'd3,
    ST_DONE  = 3'd4
  } meas_state_e;

  localparam int DEF_N_CH           = 2;
  localparam int DEF_CNT_W          = 32;
  localparam int DEF_GATE_CYCLES    = 50_000_000;
  localparam int DEF_TIMEOUT_CYCLES = 100_000_000;
  localparam int DEF_SYNC_STAGES    = 2;

  // Gate and timeout timer width; covers both default limits.
  localparam int TMR_W = 32;

endpackage

// File: rtl/square_wave_meas_ch.sv
// One reciprocal-counting channel: synchroniser, rising-edge detect, gate FSM,
// saturating period/reference/high-time counters and result registers.
module square_wave_meas_ch
  import square_wave_meter_pkg::*;
#(
  parameter int CNT_W          = DEF_CNT_W,
  parameter int GATE_CYCLES    = DEF_GATE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic             cont_mode,
  input  logic             wave_in,
  output logic             busy,
  output logic             meas_valid,
  output logic [CNT_W-1:0] edge_cnt,
  output logic [CNT_W-1:0] ref_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             timeout_flag,
  output logic             ovf_flag
);

  localparam logic [TMR_W-1:0] GATE_LAST = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic                   sync_s;
  logic                   rise_s;

  meas_state_e state_r, state_nx_s;
  logic        open_s, close_s, tout_s, tmr_clr_s, counting_s;
  logic        reopen_r;

  logic [TMR_W-1:0] tmr_r;
  logic [CNT_W-1:0] ref_r, high_r, edge_r;
  logic             ovf_r;

  logic             busy_r, valid_r, timeout_r, ovf_flag_r;
  logic [CNT_W-1:0] edge_cnt_r, ref_cnt_r, high_cnt_r;

  assign sync_s = sync_r[SYNC_STAGES-1];
  assign rise_s = sync_s & ~prev_r;

  // Input synchroniser plus the edge-detect history register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], wave_in};
      prev_r <= sync_s;
    end
  end

  // FSM state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r  <= ST_IDLE;
      reopen_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      reopen_r <= close_s & cont_mode;
      busy_r   <= (state_nx_s != ST_IDLE);
    end
  end

  // Next state; in continuous mode the closing edge reopens the gate at once
  always_comb begin
    state_nx_s = state_r;
    open_s     = 1'b0;
    close_s    = 1'b0;
    tout_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nx_s = ST_ARM;
        else       state_nx_s = ST_IDLE;
      end
      ST_ARM: begin
        if (rise_s) begin
          state_nx_s = ST_GATE;
          open_s     = 1'b1;
        end else if (tmr_r >= TOUT_LAST) begin
          state_nx_s = ST_DONE;
          tout_s     = 1'b1;
        end else begin
          state_nx_s = ST_ARM;
        end
      end
      ST_GATE: begin
        if (tmr_r >= GATE_LAST) state_nx_s = ST_CLOSE;
        else                    state_nx_s = ST_GATE;
      end
      ST_CLOSE: begin
        if (rise_s) begin
          state_nx_s = ST_DONE;
          close_s    = 1'b1;
          open_s     = cont_mode;
        end else if (tmr_r >= TOUT_LAST) begin
          state_nx_s = ST_DONE;
          tout_s     = 1'b1;
        end else begin
          state_nx_s = ST_CLOSE;
        end
      end
      ST_DONE: begin
        if (!cont_mode)    state_nx_s = ST_IDLE;
        else if (reopen_r) state_nx_s = ST_GATE;
        else               state_nx_s = ST_ARM;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Timer restarts on entry to the two waiting states and is held clear in IDLE
  always_comb begin
    tmr_clr_s  = (state_r == ST_IDLE) ||
                 ((state_nx_s != state_r) &&
                  ((state_nx_s == ST_ARM) || (state_nx_s == ST_CLOSE)));
    counting_s = (state_r == ST_GATE) || (state_r == ST_CLOSE) ||
                 ((state_r == ST_DONE) && reopen_r);
  end

  // Gate/timeout timer and the three running counters
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tmr_r  <= '0;
      ref_r  <= '0;
      high_r <= '0;
      edge_r <= '0;
      ovf_r  <= 1'b0;
    end else if (open_s) begin
      // Opening cycle t0 is already counted: one reference cycle, input high.
      tmr_r  <= TMR_W'(1);
      ref_r  <= CNT_W'(1);
      high_r <= CNT_W'(1);
      edge_r <= '0;
      ovf_r  <= 1'b0;
    end else if (counting_s) begin
      ref_r  <= sat_inc(ref_r);
      high_r <= sync_s ? sat_inc(high_r) : high_r;
      edge_r <= rise_s ? sat_inc(edge_r) : edge_r;
      ovf_r  <= ovf_r | (&ref_r) | (sync_s & (&high_r)) | (rise_s & (&edge_r));
      tmr_r  <= tmr_clr_s ? '0 : tmr_r + TMR_W'(1);
    end else begin
      tmr_r  <= tmr_clr_s ? '0 : tmr_r + TMR_W'(1);
    end
  end

  // Result registers; the closing edge itself is added to the period count
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      valid_r    <= 1'b0;
      edge_cnt_r <= '0;
      ref_cnt_r  <= '0;
      high_cnt_r <= '0;
      timeout_r  <= 1'b0;
      ovf_flag_r <= 1'b0;
    end else if (close_s) begin
      valid_r    <= 1'b1;
      edge_cnt_r <= sat_inc(edge_r);
      ref_cnt_r  <= ref_r;
      high_cnt_r <= high_r;
      timeout_r  <= 1'b0;
      ovf_flag_r <= ovf_r | (&edge_r);
    end else if (tout_s) begin
      valid_r    <= 1'b1;
      edge_cnt_r <= '0;
      ref_cnt_r  <= '0;
      high_cnt_r <= '0;
      timeout_r  <= 1'b1;
      ovf_flag_r <= 1'b0;
    end else begin
      valid_r    <= 1'b0;
    end
  end

  assign busy         = busy_r;
  assign meas_valid   = valid_r;
  assign edge_cnt     = edge_cnt_r;
  assign ref_cnt      = ref_cnt_r;
  assign high_cnt     = high_cnt_r;
  assign timeout_flag = timeout_r;
  assign ovf_flag     = ovf_flag_r;

endmodule

// File: rtl/square_wave_meter.sv
// Multi-channel square-wave frequency/duty meter: N_CH independent channels
// with their results packed onto flat buses, channel k at [k*CNT_W +: CNT_W].
module square_wave_meter
  import square_wave_meter_pkg::*;
#(
  parameter int N_CH           = DEF_N_CH,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int GATE_CYCLES    = DEF_GATE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  start,
  input  logic                  cont_mode,
  input  logic [N_CH-1:0]       wave_in,
  output logic [N_CH-1:0]       busy,
  output logic [N_CH-1:0]       meas_valid,
  output logic [N_CH*CNT_W-1:0] edge_cnt,
  output logic [N_CH*CNT_W-1:0] ref_cnt,
  output logic [N_CH*CNT_W-1:0] high_cnt,
  output logic [N_CH-1:0]       timeout_flag,
  output logic [N_CH-1:0]       ovf_flag
);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    square_wave_meas_ch #(
      .CNT_W          (CNT_W),
      .GATE_CYCLES    (GATE_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_ch (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .start        (start),
      .cont_mode    (cont_mode),
      .wave_in      (wave_in[k]),
      .busy         (busy[k]),
      .meas_valid   (meas_valid[k]),
      .edge_cnt     (edge_cnt[k*CNT_W +: CNT_W]),
      .ref_cnt      (ref_cnt[k*CNT_W +: CNT_W]),
      .high_cnt     (high_cnt[k*CNT_W +: CNT_W]),
      .timeout_flag (timeout_flag[k]),
      .ovf_flag     (ovf_flag[k])
    );
  end

endmodule

// File: tb/tb_square_wave_meter.sv
// Scoreboard bench for square_wave_meter: a 2-channel 32-bit instance and a
// 1-channel 8-bit instance driven by cycle-accurate square-wave generators.
module tb_square_wave_meter;

  localparam int GATE = 1000;
  localparam int TOUT = 4000;

  typedef struct {
    longint e_edge;
    longint e_ref;
    longint e_high;
    longint e_tout;
    longint e_ovf;
    longint at_cyc;
    longint gap;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        start8;
  logic        cont_mode;
  logic [2:0]  waves;

  logic [1:0]  busy, mv, tflag, oflag;
  logic [63:0] edge_c, ref_c, high_c;
  logic [0:0]  busy8, mv8, tflag8, oflag8;
  logic [7:0]  edge8, ref8, high8;

  longint cyc = 0;
  int     n_checks = 0;
  int     n_errors = 0;
  exp_t   q0[$], q1[$], q8[$];
  longint last0 = 0, last1 = 0, last8 = 0;

  int   w_per[3], w_hi[3], w_ph[3];
  logic w_en[3];

  square_wave_meter #(
    .N_CH(2), .CNT_W(32), .GATE_CYCLES(GATE), .TIMEOUT_CYCLES(TOUT), .SYNC_STAGES(2)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start), .cont_mode(cont_mode),
    .wave_in(waves[1:0]), .busy(busy), .meas_valid(mv), .edge_cnt(edge_c),
    .ref_cnt(ref_c), .high_cnt(high_c), .timeout_flag(tflag), .ovf_flag(oflag)
  );

  square_wave_meter #(
    .N_CH(1), .CNT_W(8), .GATE_CYCLES(GATE), .TIMEOUT_CYCLES(TOUT), .SYNC_STAGES(2)
  ) dut8 (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start8), .cont_mode(cont_mode),
    .wave_in(waves[2:2]), .busy(busy8), .meas_valid(mv8), .edge_cnt(edge8),
    .ref_cnt(ref8), .high_cnt(high8), .timeout_flag(tflag8), .ovf_flag(oflag8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input longint ed, input longint rf, input longint hi,
                              input longint to, input longint ov,
                              input longint at, input longint gap);
    exp_t e;
    e.e_edge = ed; e.e_ref = rf; e.e_high = hi;
    e.e_tout = to; e.e_ovf = ov; e.at_cyc = at; e.gap = gap;
    return e;
  endfunction

  task automatic cmp_result(input string tag, input exp_t e,
                            input longint ed, input longint rf, input longint hi,
                            input longint to, input longint ov, input longint last);
    check_val({tag, "_edge_cnt"}, ed, e.e_edge);
    check_val({tag, "_ref_cnt"}, rf, e.e_ref);
    check_val({tag, "_high_cnt"}, hi, e.e_high);
    check_val({tag, "_timeout"}, to, e.e_tout);
    check_val({tag, "_ovf"}, ov, e.e_ovf);
    if (e.at_cyc >= 0) check_val({tag, "_valid_cycle"}, cyc, e.at_cyc);
    if (e.gap >= 0)    check_val({tag, "_valid_gap"}, cyc - last, e.gap);
  endtask

  // Square-wave generators: phase 0 starts the high part of the period
  initial begin
    waves = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (w_en[k]) begin
          waves[k] = (w_ph[k] < w_hi[k]);
          w_ph[k]  = (w_ph[k] + 1 == w_per[k]) ? 0 : w_ph[k] + 1;
        end else begin
          waves[k] = 1'b0;
          w_ph[k]  = 0;
        end
      end
    end
  end

  // Result monitor: pops the per-channel scoreboard on each meas_valid
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mv[0]) begin
          if (q0.size() == 0) check_val("ch0_unexpected_valid", 64'(mv[0]), 0);
          else cmp_result("ch0", q0.pop_front(), 64'(edge_c[31:0]), 64'(ref_c[31:0]),
                          64'(high_c[31:0]), 64'(tflag[0]), 64'(oflag[0]), last0);
          last0 = cyc;
        end
        if (mv[1]) begin
          if (q1.size() == 0) check_val("ch1_unexpected_valid", 64'(mv[1]), 0);
          else cmp_result("ch1", q1.pop_front(), 64'(edge_c[63:32]), 64'(ref_c[63:32]),
                          64'(high_c[63:32]), 64'(tflag[1]), 64'(oflag[1]), last1);
          last1 = cyc;
        end
        if (mv8[0]) begin
          if (q8.size() == 0) check_val("w8_unexpected_valid", 64'(mv8[0]), 0);
          else cmp_result("w8", q8.pop_front(), 64'(edge8), 64'(ref8), 64'(high8),
                          64'(tflag8[0]), 64'(oflag8[0]), last8);
          last8 = cyc;
        end
      end
    end
  end

  task automatic set_wave(input int k, input int per, input int hi);
    w_en[k] = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    w_per[k] = per;
    w_hi[k]  = hi;
    w_en[k]  = (per != 0);
  endtask

  task automatic pulse_start(input logic wide, output longint sc);
    @(negedge clk);
    if (wide) start = 1'b1;
    else      start8 = 1'b1;
    sc = cyc;
    @(negedge clk);
    start  = 1'b0;
    start8 = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int i = 0;
    while ((q0.size() + q1.size() + q8.size()) != 0 && i < budget) begin
      @(posedge clk);
      i++;
    end
    check_val("scoreboard_drained", q0.size() + q1.size() + q8.size(), 0);
    q0.delete();
    q1.delete();
    q8.delete();
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_busy"}, 64'({busy, busy8}), 0);
    check_val({tag, "_meas_valid"}, 64'({mv, mv8}), 0);
    check_val({tag, "_edge_cnt"}, longint'(edge_c) | 64'(edge8), 0);
    check_val({tag, "_ref_cnt"}, longint'(ref_c) | 64'(ref8), 0);
    check_val({tag, "_high_cnt"}, longint'(high_c) | 64'(high8), 0);
    check_val({tag, "_flags"}, 64'({tflag, oflag, tflag8, oflag8}), 0);
  endtask

  initial begin
    longint sc;
    int     i;
    rst_n = 1'b0; start = 1'b0; start8 = 1'b0; cont_mode = 1'b0;
    for (int k = 0; k < 3; k++) begin
      w_en[k] = 1'b0; w_per[k] = 0; w_hi[k] = 0;
    end
    repeat (4) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Single shot: ch0 48/12 and ch1 100/70 from one start
    set_wave(0, 48, 12);
    set_wave(1, 100, 70);
    repeat (10) @(negedge clk);
    pulse_start(1'b1, sc);
    check_val("busy_after_start", 64'(busy), 3);
    q0.push_back(mk(21, 1008, 252, 0, 0, -1, -1));
    q1.push_back(mk(10, 1000, 700, 0, 0, -1, -1));
    repeat (200) @(negedge clk);
    pulse_start(1'b1, sc);
    wait_drain(3000);
    repeat (3) @(negedge clk);
    check_val("busy_after_single", 64'(busy), 0);

    // Closing edge lands exactly on gate expiry
    set_wave(0, 50, 25);
    pulse_start(1'b1, sc);
    q0.push_back(mk(20, 1000, 500, 0, 0, -1, -1));
    q1.push_back(mk(10, 1000, 700, 0, 0, -1, -1));
    wait_drain(3000);

    // Both inputs held low: timeout from ARM
    set_wave(0, 0, 0);
    set_wave(1, 0, 0);
    repeat (10) @(negedge clk);
    pulse_start(1'b1, sc);
    q0.push_back(mk(0, 0, 0, 1, 0, sc + TOUT + 1, -1));
    q1.push_back(mk(0, 0, 0, 1, 0, sc + TOUT + 1, -1));
    wait_drain(6000);
    repeat (3) @(negedge clk);
    check_val("busy_after_timeout", 64'(busy), 0);

    // Continuous mode: four back-to-back results, then drop cont_mode
    set_wave(0, 48, 12);
    set_wave(1, 100, 70);
    cont_mode = 1'b1;
    pulse_start(1'b1, sc);
    q0.push_back(mk(21, 1008, 252, 0, 0, -1, -1));
    q1.push_back(mk(10, 1000, 700, 0, 0, -1, -1));
    for (int n = 0; n < 3; n++) begin
      q0.push_back(mk(21, 1008, 252, 0, 0, -1, 1008));
      q1.push_back(mk(10, 1000, 700, 0, 0, -1, 1000));
    end
    i = 0;
    while ((q0.size() > 1 || q1.size() > 1) && i < 6000) begin
      @(posedge clk);
      i++;
    end
    @(posedge clk);
    #1 cont_mode = 1'b0;
    wait_drain(3000);
    repeat (3) @(negedge clk);
    check_val("busy_after_cont", 64'(busy), 0);
    repeat (1200) @(negedge clk);

    // 8-bit counters saturate on the reference count only
    set_wave(2, 48, 12);
    pulse_start(1'b0, sc);
    q8.push_back(mk(21, 255, 252, 0, 1, -1, -1));
    wait_drain(3000);

    // Asynchronous reset mid-gate clears everything; no result follows
    pulse_start(1'b1, sc);
    repeat (500) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("midgate_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3000) @(negedge clk);
    check_val("busy_after_reset", 64'({busy, busy8}), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
